// File: rtl/avmm_cfg_pkg.sv
// rtl/avmm_cfg_pkg.sv - shared types and address field positions for the AVMM config responder
package avmm_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte address layout: [16:11] channel, [10:2] word, [1:0] ignored
  localparam int ADDR_W   = 17;
  localparam int CH_LSB   = 11;
  localparam int CH_W     = 6;
  localparam int WORD_LSB = 2;
  localparam int WORD_W   = 9;

  // Bit positions inside the read-only STATUS word
  localparam int STATUS_TX_BIT = 0;
  localparam int STATUS_RX_BIT = 1;

endpackage

// File: rtl/avmm_cfg_regbank.sv
// rtl/avmm_cfg_regbank.sv - byte-enabled per-channel RW register array plus read mux
module avmm_cfg_regbank
  import avmm_cfg_pkg::*;
#(
  parameter int ACTIVE_CHNLS  = 2,
  parameter int REGS_PER_CHNL = 8,
  parameter int AVMM_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 4
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                wr_en,
  input  logic [CH_W-1:0]                                     wr_ch,
  input  logic [WORD_W-1:0]                                   wr_word,
  input  logic [BYTE_WIDTH-1:0]                               byte_en,
  input  logic [AVMM_WIDTH-1:0]                               wdata,
  input  logic [CH_W-1:0]                                     rd_ch,
  input  logic [WORD_W-1:0]                                   rd_word,
  input  logic [ACTIVE_CHNLS-1:0]                             tx_transfer_en,
  input  logic [ACTIVE_CHNLS-1:0]                             rx_align_done,
  output logic [AVMM_WIDTH-1:0]                               rd_data,
  output logic [ACTIVE_CHNLS*(REGS_PER_CHNL-1)*AVMM_WIDTH-1:0] cfg_regs
);

  localparam int RW_WORDS = REGS_PER_CHNL - 1;

  // Byte-enabled update of the addressed RW word; the STATUS word has no storage,
  // so a write aimed at it simply matches nothing here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_regs <= '0;
    end else if (wr_en) begin
      for (int c = 0; c < ACTIVE_CHNLS; c++) begin
        for (int w = 0; w < RW_WORDS; w++) begin
          if (wr_ch == CH_W'(c) && wr_word == WORD_W'(w)) begin
            for (int b = 0; b < BYTE_WIDTH; b++) begin
              if (byte_en[b]) begin
                cfg_regs[((c*RW_WORDS + w)*AVMM_WIDTH + b*8) +: 8] <= wdata[b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  // Read mux: RW words from storage, last word built from the live status inputs
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < ACTIVE_CHNLS; c++) begin
      if (rd_ch == CH_W'(c)) begin
        for (int w = 0; w < RW_WORDS; w++) begin
          if (rd_word == WORD_W'(w)) begin
            rd_data = cfg_regs[(c*RW_WORDS + w)*AVMM_WIDTH +: AVMM_WIDTH];
          end
        end
        if (rd_word == WORD_W'(RW_WORDS)) begin
          rd_data[STATUS_TX_BIT] = tx_transfer_en[c];
          rd_data[STATUS_RX_BIT] = rx_align_done[c];
        end
      end
    end
  end

endmodule

// File: rtl/avmm_cfg_responder.sv
// rtl/avmm_cfg_responder.sv - Avalon-MM configuration target: command FSM, decode, read data return
module avmm_cfg_responder
  import avmm_cfg_pkg::*;
#(
  parameter int ACTIVE_CHNLS  = 2,
  parameter int REGS_PER_CHNL = 8,
  parameter int AVMM_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 4
) (
  input  logic                                                i_cfg_avmm_clk,
  input  logic                                                i_cfg_avmm_rst,
  input  logic [ADDR_W-1:0]                                   i_cfg_avmm_addr,
  input  logic [BYTE_WIDTH-1:0]                               i_cfg_avmm_byte_en,
  input  logic                                                i_cfg_avmm_read,
  input  logic                                                i_cfg_avmm_write,
  input  logic [AVMM_WIDTH-1:0]                               i_cfg_avmm_wdata,
  output logic                                                o_cfg_avmm_waitreq,
  output logic                                                o_cfg_avmm_rdatavld,
  output logic [AVMM_WIDTH-1:0]                               o_cfg_avmm_rdata,
  input  logic [ACTIVE_CHNLS-1:0]                             i_tx_transfer_en,
  input  logic [ACTIVE_CHNLS-1:0]                             i_rx_align_done,
  output logic [ACTIVE_CHNLS*(REGS_PER_CHNL-1)*AVMM_WIDTH-1:0] o_cfg_regs,
  output logic                                                o_decode_err
);

  state_t                  state, state_nxt;
  logic [CH_W-1:0]         cmd_ch;
  logic [WORD_W-1:0]       cmd_word;
  logic [BYTE_WIDTH-1:0]   cmd_be;
  logic [AVMM_WIDTH-1:0]   cmd_wdata;
  logic                    cmd_read;
  logic                    cmd_write;
  logic                    cmd_hit;
  logic                    cmd_both;
  logic                    wr_en;
  logic [AVMM_WIDTH-1:0]   rd_data;

  // Sub-word byte offset carries no meaning for word registers
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, i_cfg_avmm_addr[WORD_LSB-1:0]};

  assign cmd_hit  = (cmd_ch < CH_W'(ACTIVE_CHNLS)) && (cmd_word < WORD_W'(REGS_PER_CHNL));
  assign cmd_both = cmd_read && cmd_write;
  assign wr_en    = (state == ACK) && cmd_write && cmd_hit;

  // State register
  always_ff @(posedge i_cfg_avmm_clk or posedge i_cfg_avmm_rst) begin
    if (i_cfg_avmm_rst) state <= IDLE;
    else                state <= state_nxt;
  end

  // Capture the command in IDLE; everything after uses only these copies
  always_ff @(posedge i_cfg_avmm_clk or posedge i_cfg_avmm_rst) begin
    if (i_cfg_avmm_rst) begin
      cmd_ch    <= '0;
      cmd_word  <= '0;
      cmd_be    <= '0;
      cmd_wdata <= '0;
      cmd_read  <= 1'b0;
      cmd_write <= 1'b0;
    end else if (state == IDLE && (i_cfg_avmm_read || i_cfg_avmm_write)) begin
      cmd_ch    <= i_cfg_avmm_addr[CH_LSB +: CH_W];
      cmd_word  <= i_cfg_avmm_addr[WORD_LSB +: WORD_W];
      cmd_be    <= i_cfg_avmm_byte_en;
      cmd_wdata <= i_cfg_avmm_wdata;
      cmd_read  <= i_cfg_avmm_read;
      cmd_write <= i_cfg_avmm_write;
    end
  end

  // Next-state: fixed IDLE -> ACK -> RESP walk once a request appears
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_cfg_avmm_read || i_cfg_avmm_write) state_nxt = ACK;
      ACK:     state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: waitreq drops only in ACK; response flags are qualified by RESP
  always_comb begin
    o_cfg_avmm_waitreq  = 1'b1;
    o_cfg_avmm_rdatavld = 1'b0;
    o_decode_err        = 1'b0;
    case (state)
      ACK:  o_cfg_avmm_waitreq = 1'b0;
      RESP: begin
        o_cfg_avmm_rdatavld = cmd_read && !cmd_write;
        o_decode_err        = !cmd_hit || cmd_both;
      end
      default: ;
    endcase
  end

  // Read data register: loaded only by a pure read, zero on a decode miss
  always_ff @(posedge i_cfg_avmm_clk or posedge i_cfg_avmm_rst) begin
    if (i_cfg_avmm_rst) begin
      o_cfg_avmm_rdata <= '0;
    end else if (state == ACK && cmd_read && !cmd_write) begin
      o_cfg_avmm_rdata <= cmd_hit ? rd_data : '0;
    end
  end

  avmm_cfg_regbank #(
    .ACTIVE_CHNLS  (ACTIVE_CHNLS),
    .REGS_PER_CHNL (REGS_PER_CHNL),
    .AVMM_WIDTH    (AVMM_WIDTH),
    .BYTE_WIDTH    (BYTE_WIDTH)
  ) u_regbank (
    .clk            (i_cfg_avmm_clk),
    .rst            (i_cfg_avmm_rst),
    .wr_en          (wr_en),
    .wr_ch          (cmd_ch),
    .wr_word        (cmd_word),
    .byte_en        (cmd_be),
    .wdata          (cmd_wdata),
    .rd_ch          (cmd_ch),
    .rd_word        (cmd_word),
    .tx_transfer_en (i_tx_transfer_en),
    .rx_align_done  (i_rx_align_done),
    .rd_data        (rd_data),
    .cfg_regs       (o_cfg_regs)
  );

endmodule

// File: tb/tb_avmm_cfg_responder.sv
// tb/tb_avmm_cfg_responder.sv - scoreboard bench for avmm_cfg_responder
module tb_avmm_cfg_responder;

  localparam int NCH  = 2;
  localparam int NREG = 8;
  localparam int W    = 32;
  localparam int BW   = 4;
  localparam int RW   = NCH*(NREG-1)*W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [16:0]     addr = '0;
  logic [BW-1:0]   byte_en = '0;
  logic            rd = 1'b0;
  logic            wr = 1'b0;
  logic [W-1:0]    wdata = '0;
  logic            waitreq;
  logic            rdatavld;
  logic [W-1:0]    rdata;
  logic [NCH-1:0]  tx_en = '0;
  logic [NCH-1:0]  rx_done = '0;
  logic [RW-1:0]   cfg_regs;
  logic            decode_err;

  logic [RW-1:0]   model = '0;

  typedef struct {
    string      name;
    bit         rdv;
    logic [W-1:0] data;
    bit         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  avmm_cfg_responder #(
    .ACTIVE_CHNLS (NCH),
    .REGS_PER_CHNL(NREG),
    .AVMM_WIDTH   (W),
    .BYTE_WIDTH   (BW)
  ) dut (
    .i_cfg_avmm_clk     (clk),
    .i_cfg_avmm_rst     (rst),
    .i_cfg_avmm_addr    (addr),
    .i_cfg_avmm_byte_en (byte_en),
    .i_cfg_avmm_read    (rd),
    .i_cfg_avmm_write   (wr),
    .i_cfg_avmm_wdata   (wdata),
    .o_cfg_avmm_waitreq (waitreq),
    .o_cfg_avmm_rdatavld(rdatavld),
    .o_cfg_avmm_rdata   (rdata),
    .i_tx_transfer_en   (tx_en),
    .i_rx_align_done    (rx_done),
    .o_cfg_regs         (cfg_regs),
    .o_decode_err       (decode_err)
  );

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference write into the bench's own copy of the RW bank
  task automatic model_write(input logic [16:0] a, input logic [BW-1:0] be, input logic [W-1:0] d);
    int ch, wd;
    ch = int'(a[16:11]);
    wd = int'(a[10:2]);
    if (ch < NCH && wd < NREG-1) begin
      for (int b = 0; b < BW; b++)
        if (be[b]) model[(ch*(NREG-1)+wd)*W + b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  // Issue one access; expected response goes to the scoreboard
  task automatic access(input string nm, input logic [16:0] a, input logic [BW-1:0] be,
                        input bit r, input bit w, input logic [W-1:0] d,
                        input bit e_rdv, input logic [W-1:0] e_data, input bit e_err);
    int n;
    exp_t e;
    e.name = nm; e.rdv = e_rdv; e.data = e_data; e.err = e_err;
    exp_q.push_back(e);
    addr = a; byte_en = be; rd = r; wr = w; wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (waitreq && n < 20);
    chk({nm, "_accept_timeout"}, RW'(waitreq), RW'(1'b0));
    // Scramble the bus during ACK: only the values latched in IDLE may be used
    rd = 1'b0; wr = 1'b0; addr = 17'h1FFFF; wdata = 32'hDEAD_BEEF; byte_en = '1;
    @(negedge clk);
    chk({nm, "_regs"}, cfg_regs, model);
    @(negedge clk);
  endtask

  // Monitor: an acceptance seen on one falling edge means the response is due on the next
  initial begin
    bit pending = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
      end else if (pending) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_response: got a response with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_rdatavld"}, RW'(rdatavld), RW'(e.rdv));
          chk({e.name, "_decode_err"}, RW'(decode_err), RW'(e.err));
          if (e.rdv) chk({e.name, "_rdata"}, RW'(rdata), RW'(e.data));
        end
      end else begin
        chk("idle_rdatavld", RW'(rdatavld), RW'(1'b0));
        chk("idle_decode_err", RW'(decode_err), RW'(1'b0));
      end
      pending = !rst && !waitreq;
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_waitreq", RW'(waitreq), RW'(1'b1));
    chk("reset_rdatavld", RW'(rdatavld), RW'(1'b0));
    chk("reset_rdata", RW'(rdata), RW'(0));
    chk("reset_decode_err", RW'(decode_err), RW'(1'b0));
    chk("reset_cfg_regs", cfg_regs, '0);
    @(negedge clk);

    access("rd_ch0_w0", 17'h00000, 4'h0, 1, 0, 32'h0, 1, 32'h0000_0000, 0);

    model_write(17'h00804, 4'b0101, 32'hA5A5_5A5A);
    access("wr_ch1_w1", 17'h00804, 4'b0101, 0, 1, 32'hA5A5_5A5A, 0, 32'h0, 0);
    chk("ch1_w1_slice", RW'(cfg_regs[(1*(NREG-1)+1)*W +: W]), RW'(32'h00A5_005A));
    access("rd_ch1_w1", 17'h00804, 4'h0, 1, 0, 32'h0, 1, 32'h00A5_005A, 0);

    tx_en = 2'b10; rx_done = 2'b10;
    access("rd_ch1_status", 17'h0081C, 4'h0, 1, 0, 32'h0, 1, 32'h0000_0003, 0);
    access("wr_ch1_status", 17'h0081C, 4'hF, 0, 1, 32'hFFFF_FFFF, 0, 32'h0, 0);
    access("rd_ch1_status2", 17'h0081C, 4'h0, 1, 0, 32'h0, 1, 32'h0000_0003, 0);
    access("rd_ch0_status", 17'h0001C, 4'h0, 1, 0, 32'h0, 1, 32'h0000_0000, 0);

    access("rd_miss_ch2", 17'h01000, 4'h0, 1, 0, 32'h0, 1, 32'h0000_0000, 1);
    access("wr_miss_ch2", 17'h01000, 4'hF, 0, 1, 32'hFFFF_FFFF, 0, 32'h0, 1);
    access("rd_miss_word8", 17'h00020, 4'h0, 1, 0, 32'h0, 1, 32'h0000_0000, 1);
    access("rd_after_miss", 17'h00804, 4'h0, 1, 0, 32'h0, 1, 32'h00A5_005A, 0);

    model_write(17'h00008, 4'hF, 32'h1234_5678);
    access("rdwr_ch0_w2", 17'h00008, 4'hF, 1, 1, 32'h1234_5678, 0, 32'h0, 1);
    access("rd_ch0_w2", 17'h00008, 4'h0, 1, 0, 32'h0, 1, 32'h1234_5678, 0);

    model_write(17'h0080B, 4'b1000, 32'h7700_0000);
    access("wr_ch1_w2_lsbs", 17'h0080B, 4'b1000, 0, 1, 32'h7700_0000, 0, 32'h0, 0);
    access("rd_ch1_w2", 17'h00808, 4'h0, 1, 0, 32'h0, 1, 32'h7700_0000, 0);

    // Reset while a write sits in ACK: nothing may be committed
    addr = 17'h00004; byte_en = 4'hF; wr = 1'b1; wdata = 32'hFFFF_FFFF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (waitreq && n < 20);
    chk("abort_accept_timeout", RW'(waitreq), RW'(1'b0));
    #1 rst = 1'b1;
    wr = 1'b0;
    model = '0;
    #1;
    chk("abort_waitreq", RW'(waitreq), RW'(1'b1));
    chk("abort_rdatavld", RW'(rdatavld), RW'(1'b0));
    chk("abort_rdata", RW'(rdata), RW'(0));
    chk("abort_cfg_regs", cfg_regs, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access("rd_ch0_w1_after_abort", 17'h00004, 4'h0, 1, 0, 32'h0, 1, 32'h0000_0000, 0);
    access("rd_ch1_w1_after_abort", 17'h00804, 4'h0, 1, 0, 32'h0, 1, 32'h0000_0000, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", RW'(exp_q.size()), RW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
